// File: rtl/l2_burst_adapter.sv
// ============================================================================
//  Module   : l2_burst_adapter
//  Purpose  : Memory-side responder for the L2 line interface. Splits each
//             256-bit line read/write into a 4-beat, 64-bit burst toward
//             physical memory and returns the assembled line or a completion
//             pulse to the L2.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module l2_burst_adapter #(
    parameter int S_OFFSET  = 5,
    parameter int S_LINE    = 256,
    parameter int S_BURST   = 64,
    parameter int NUM_BEATS = S_LINE / S_BURST
) (
    input  logic                clk,
    input  logic                rst,            // asynchronous, active-low
    input  logic [31:0]         line_address,
    input  logic [S_LINE-1:0]   line_wdata,
    input  logic                line_read,
    input  logic                line_write,
    output logic [S_LINE-1:0]   line_rdata,
    output logic                line_resp,
    output logic [31:0]         burst_address,
    output logic [S_BURST-1:0]  burst_wdata,
    input  logic [S_BURST-1:0]  burst_rdata,
    output logic                burst_read,
    output logic                burst_write,
    input  logic                burst_resp,
    output logic [31:0]         read_count,
    output logic [31:0]         write_count
);

    localparam int          BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BEATS - 1);
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << S_OFFSET) - 32'd1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t              state_q,       state_d;
    logic [BW-1:0]       beat_cnt_q,    beat_cnt_d;
    logic [31:0]         addr_q,        addr_d;
    logic [S_LINE-1:0]   wbuf_q,        wbuf_d;
    logic [S_LINE-1:0]   rbuf_q,        rbuf_d;
    logic                op_write_q,    op_write_d;     // type of the line in flight
    logic [31:0]         read_count_q,  read_count_d;
    logic [31:0]         write_count_q, write_count_d;

    // State and datapath registers; reset abandons any burst in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            beat_cnt_q    <= '0;
            addr_q        <= '0;
            wbuf_q        <= '0;
            rbuf_q        <= '0;
            op_write_q    <= 1'b0;
            read_count_q  <= '0;
            write_count_q <= '0;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            addr_q        <= addr_d;
            wbuf_q        <= wbuf_d;
            rbuf_q        <= rbuf_d;
            op_write_q    <= op_write_d;
            read_count_q  <= read_count_d;
            write_count_q <= write_count_d;
        end
    end

    // Next-state: accept (write has priority), step beats on burst_resp, count completions
    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        addr_d        = addr_q;
        wbuf_d        = wbuf_q;
        rbuf_d        = rbuf_q;
        op_write_d    = op_write_q;
        read_count_d  = read_count_q;
        write_count_d = write_count_q;

        case (state_q)
            IDLE: begin
                if (line_write) begin
                    addr_d     = line_address & ADDR_MASK;
                    wbuf_d     = line_wdata;
                    beat_cnt_d = '0;
                    op_write_d = 1'b1;
                    state_d    = WR_BURST;
                end else if (line_read) begin
                    addr_d     = line_address & ADDR_MASK;
                    beat_cnt_d = '0;
                    op_write_d = 1'b0;
                    state_d    = RD_BURST;
                end
            end
            RD_BURST: begin
                if (burst_resp) begin
                    rbuf_d[int'(beat_cnt_q)*S_BURST +: S_BURST] = burst_rdata;
                    beat_cnt_d = beat_cnt_q + BW'(1);
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            WR_BURST: begin
                if (burst_resp) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (op_write_q) begin
                    write_count_d = write_count_q + 32'd1;
                end else begin
                    read_count_d  = read_count_q + 32'd1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from registered state and buffers
    assign burst_read    = (state_q == RD_BURST);
    assign burst_write   = (state_q == WR_BURST);
    assign line_resp     = (state_q == DONE);
    assign burst_address = addr_q;
    assign burst_wdata   = wbuf_q[int'(beat_cnt_q)*S_BURST +: S_BURST];
    assign line_rdata    = rbuf_q;
    assign read_count    = read_count_q;
    assign write_count   = write_count_q;

endmodule

`default_nettype wire

// File: doc/l2_burst_adapter.md
Name: l2_burst_adapter

Overview:
- Memory-side responder for the L2 physical-memory line interface (256-bit line read/write, level request, single-cycle resp).
- Converts each line request into a 4-beat, 64-bit burst toward physical memory.
- Returns the assembled line, or a completion pulse, to the L2.
- Sits between the L2 cache's pmem_* ports and the memory model or DRAM controller.

Parameters:
- s_offset, 5, line offset bits (line = 32 bytes)
- s_line, 256, line width in bits
- s_burst, 64, burst beat width in bits
- num_beats, s_line/s_burst (4), beats per line

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- line_address  in  32  line request address (byte address; low s_offset bits ignored)
- line_wdata  in  256  write line
- line_read  in  1  line read request (level, held until line_resp)
- line_write  in  1  line write request (level, held until line_resp)
- line_rdata  out  256  assembled read line
- line_resp  out  1  one-cycle completion pulse
- burst_address  out  32  aligned burst address
- burst_wdata  out  64  current write beat
- burst_rdata  in  64  current read beat
- burst_read  out  1  burst read request
- burst_write  out  1  burst write request
- burst_resp  in  1  one beat transferred this cycle
- read_count  out  32  completed line reads
- write_count  out  32  completed line writes

Behaviour:
- Reset (rst=0, async) clears all of the following to 0 and forces state IDLE:
  - state, beat_cnt, address latch, write buffer, read buffer (line_rdata)
  - line_resp, burst_read, burst_write, read_count, write_count
- Reset mid-burst abandons the transaction. No line_resp is issued.
- States: IDLE, RD_BURST, WR_BURST, DONE. Outputs are Moore (decoded from registered state/buffers).
- IDLE:
  - If line_write=1, latch {line_address[31:5],5'b0}, latch line_wdata into the write buffer, set beat_cnt=0, go to WR_BURST.
  - Else if line_read=1, latch the address, set beat_cnt=0, go to RD_BURST.
  - Simultaneous read and write: write wins; the read is not serviced.
- RD_BURST:
  - burst_read=1, burst_address=latched address.
  - Each cycle with burst_resp=1: read buffer[64*beat_cnt +: 64] <= burst_rdata, beat_cnt++.
  - On the resp with beat_cnt==num_beats-1, go to DONE.
  - Beat 0 maps to bits 63:0.
  - Gaps (burst_resp=0) between beats are allowed and stall.
- WR_BURST:
  - burst_write=1, burst_wdata = write buffer[64*beat_cnt +: 64].
  - Advance on burst_resp exactly as in RD_BURST.
  - On the last beat, go to DONE.
- DONE:
  - line_resp=1 for exactly one cycle; burst_read/burst_write=0.
  - Increment read_count or write_count according to the completed type; counts wrap at 2^32.
  - Next state: IDLE.
- line_rdata holds the last completed read line until the next read burst begins overwriting beats. It is not modified by writes.
- burst_read and burst_write are never asserted together and are 0 in IDLE and DONE.
- burst_resp in IDLE or DONE is ignored.
- line_address and line_wdata changes after acceptance are ignored (latched).
- Requester must deassert its request in the cycle after line_resp. The IDLE cycle following DONE samples requests normally, so a held request starts a new transaction.
- Minimum latency, request to line_resp, with back-to-back burst_resp: 1 (accept) + 4 (beats) + 1 (DONE) = 6 cycles.
- All state is updated on the rising clk edge.

Test Plan:
- Reset: hold rst=0 mid-RD_BURST after 2 beats, then release -> all outputs 0, state IDLE, no line_resp, counters 0.
- Read, back-to-back resp:
  - Stimulus: line_read, line_address=0x0000_1234; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - Response: burst_address=0x0000_1220; line_rdata={0x44..44,0x33..33,0x22..22,0x11..11}; line_resp 6 cycles after request; read_count=1.
- Write with gaps:
  - Stimulus: line_write, line_wdata=256'hDDDD..CCCC..BBBB..AAAA, resp on cycles 2,5,6,9.
  - Response: burst_wdata sequence 0xAAAA..,0xBBBB..,0xCCCC..,0xDDDD.., each held until its resp; single line_resp; write_count=1.
- Simultaneous line_read=1 and line_write=1 in IDLE -> WR_BURST taken, burst_read never asserted.
- Stray burst_resp=1 in IDLE for 3 cycles, then a read -> beat_cnt unaffected, all 4 beats are captured from the read.
- Counter wrap: preload read_count to 0xFFFF_FFFF via 2^32-1 forced, or bench-forced, state -> one more read yields read_count=0.
